// File: rtl/superh16_int_wb_arbiter.sv
// Integer writeback arbiter: per-source result FIFOs drained round-robin onto NUM_WB ports.
// Defining SUPERH16_WB_PERF_CNT_EN adds the wb_conflict_cnt performance counter output.
package superh16_pkg;
    parameter int XLEN          = 64;
    parameter int PHYS_REG_BITS = 8;
    parameter int ROB_IDX_BITS  = 8;
endpackage

module superh16_int_wb_arbiter
    import superh16_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int NUM_WB       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic [NUM_SRC-1:0]                     src_valid,
    input  logic [NUM_SRC-1:0][XLEN-1:0]           src_result,
    input  logic [NUM_SRC-1:0][PHYS_REG_BITS-1:0]  src_dst_tag,
    input  logic [NUM_SRC-1:0][ROB_IDX_BITS-1:0]   src_rob_idx,
    input  logic [NUM_SRC-1:0]                     src_exception,
    input  logic [NUM_SRC-1:0][7:0]                src_exception_code,
    output logic [NUM_SRC-1:0]                     src_stall,
    output logic [NUM_WB-1:0]                      wb_valid,
    output logic [NUM_WB-1:0][XLEN-1:0]            wb_result,
    output logic [NUM_WB-1:0][PHYS_REG_BITS-1:0]   wb_dst_tag,
    output logic [NUM_WB-1:0][ROB_IDX_BITS-1:0]    wb_rob_idx,
    output logic [NUM_WB-1:0]                      wb_exception,
    output logic [NUM_WB-1:0][7:0]                 wb_exception_code,
    output logic                                   overflow_err
`ifdef SUPERH16_WB_PERF_CNT_EN
    ,
    output logic [31:0]                            wb_conflict_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [PHYS_REG_BITS-1:0] dst_tag;
        logic [ROB_IDX_BITS-1:0]  rob_idx;
        logic                     exception;
        logic [7:0]               code;
    } entry_t;

    entry_t                        mem_q [NUM_SRC][FIFO_DEPTH];
    logic [NUM_SRC-1:0][PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_SRC-1:0]            stall_q, stall_d;
    logic [SRC_W-1:0]              rr_q, rr_d;
    logic [NUM_WB-1:0]             wb_vld_q, wb_vld_d;
    entry_t [NUM_WB-1:0]           wb_e_q, wb_e_d;
    logic                          ovf_q;
    entry_t [NUM_SRC-1:0]          in_e, cand_e;
    logic [NUM_SRC-1:0]            cand, grant, pop, wr_en, drop;
    logic                          conflict;

    // Candidate selection and round-robin scan starting at rr_q
    always_comb begin
        int n;
        int idx;
        n        = 0;
        idx      = 0;
        grant    = '0;
        wb_vld_d = '0;
        wb_e_d   = '0;
        rr_d     = rr_q;
        for (int s = 0; s < NUM_SRC; s++) begin
            in_e[s]   = '{result: src_result[s], dst_tag: src_dst_tag[s], rob_idx: src_rob_idx[s],
                          exception: src_exception[s], code: src_exception_code[s]};
            cand[s]   = (cnt_q[s] != '0) || src_valid[s];
            cand_e[s] = (cnt_q[s] != '0) ? mem_q[s][rd_ptr_q[s]] : in_e[s];
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (s == idx && cand[s] && n < NUM_WB) begin
                    for (int p = 0; p < NUM_WB; p++) begin
                        if (p == n) begin
                            wb_vld_d[p] = 1'b1;
                            wb_e_d[p]   = cand_e[s];
                        end
                    end
                    grant[s] = 1'b1;
                    n        = n + 1;
                    rr_d     = (s == NUM_SRC - 1) ? '0 : SRC_W'(s + 1);
                end
            end
        end
        conflict = |(cand & ~grant);
    end

    // A bypassed entry never touches the FIFO; a push into a full FIFO is only legal alongside a pop
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            pop[s]     = grant[s] && (cnt_q[s] != '0);
            drop[s]    = src_valid[s] && (cnt_q[s] == CNT_W'(FIFO_DEPTH)) && !pop[s];
            wr_en[s]   = src_valid[s] && !(grant[s] && (cnt_q[s] == '0)) && !drop[s];
            cnt_d[s]   = cnt_q[s] + CNT_W'(wr_en[s]) - CNT_W'(pop[s]);
            stall_d[s] = (FIFO_DEPTH - int'(cnt_d[s])) <= STALL_MARGIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            stall_q  <= '0;
            rr_q     <= '0;
            wb_vld_q <= '0;
            wb_e_q   <= '0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            stall_q  <= '0;
            wb_vld_q <= '0;
            wb_e_q   <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (pop[s])   rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(1);
                if (wr_en[s]) wr_ptr_q[s] <= wr_ptr_q[s] + PTR_W'(1);
            end
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            rr_q     <= rr_d;
            wb_vld_q <= wb_vld_d;
            wb_e_q   <= wb_e_d;
            if (|drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (wr_en[s] && !flush) mem_q[s][wr_ptr_q[s]] <= in_e[s];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_WB; p++) begin
            wb_result[p]         = wb_e_q[p].result;
            wb_dst_tag[p]        = wb_e_q[p].dst_tag;
            wb_rob_idx[p]        = wb_e_q[p].rob_idx;
            wb_exception[p]      = wb_e_q[p].exception;
            wb_exception_code[p] = wb_e_q[p].code;
        end
    end

    assign wb_valid     = wb_vld_q;
    assign src_stall    = stall_q;
    assign overflow_err = ovf_q;

`ifdef SUPERH16_WB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
        end else if (conflict && conflict_cnt_q != '1) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign wb_conflict_cnt = conflict_cnt_q;
`else
    logic unused_conflict;
    assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_superh16_int_wb_arbiter.sv
// Directed self-checking bench for superh16_int_wb_arbiter (default build, 4 sources, 2 ports).
module tb_superh16_int_wb_arbiter;
    import superh16_pkg::*;

    localparam int NS = 4;
    localparam int NW = 2;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              flush;
    logic [NS-1:0]                     src_valid;
    logic [NS-1:0][XLEN-1:0]           src_result;
    logic [NS-1:0][PHYS_REG_BITS-1:0]  src_dst_tag;
    logic [NS-1:0][ROB_IDX_BITS-1:0]   src_rob_idx;
    logic [NS-1:0]                     src_exception;
    logic [NS-1:0][7:0]                src_exception_code;
    logic [NS-1:0]                     src_stall;
    logic [NW-1:0]                     wb_valid;
    logic [NW-1:0][XLEN-1:0]           wb_result;
    logic [NW-1:0][PHYS_REG_BITS-1:0]  wb_dst_tag;
    logic [NW-1:0][ROB_IDX_BITS-1:0]   wb_rob_idx;
    logic [NW-1:0]                     wb_exception;
    logic [NW-1:0][7:0]                wb_exception_code;
    logic                              overflow_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    superh16_int_wb_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .src_valid          (src_valid),
        .src_result         (src_result),
        .src_dst_tag        (src_dst_tag),
        .src_rob_idx        (src_rob_idx),
        .src_exception      (src_exception),
        .src_exception_code (src_exception_code),
        .src_stall          (src_stall),
        .wb_valid           (wb_valid),
        .wb_result          (wb_result),
        .wb_dst_tag         (wb_dst_tag),
        .wb_rob_idx         (wb_rob_idx),
        .wb_exception       (wb_exception),
        .wb_exception_code  (wb_exception_code),
        .overflow_err       (overflow_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush              = 1'b0;
        src_valid          = '0;
        src_result         = '0;
        src_dst_tag        = '0;
        src_rob_idx        = '0;
        src_exception      = '0;
        src_exception_code = '0;
    endtask

    task automatic set_src(input logic [1:0] s, input logic [XLEN-1:0] r, input logic [7:0] t,
                           input logic [7:0] ro, input logic e, input logic [7:0] c);
        src_valid[s]          = 1'b1;
        src_result[s]         = r;
        src_dst_tag[s]        = t;
        src_rob_idx[s]        = ro;
        src_exception[s]      = e;
        src_exception_code[s] = c;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        total++; if (wb_valid !== 2'b00) begin bad++; $display("FAIL reset_wb_valid got=%b exp=00", wb_valid); end
        total++; if (src_stall !== 4'h0) begin bad++; $display("FAIL reset_src_stall got=%h exp=0", src_stall); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow_err); end
        total++; if (wb_result !== '0 || wb_dst_tag !== '0) begin bad++; $display("FAIL reset_wb_data got=%h/%h exp=0", wb_result, wb_dst_tag); end
        step();
        rst_n = 1'b1;
        step();
        total++; if (wb_valid !== 2'b00) begin bad++; $display("FAIL post_reset_idle got=%b exp=00", wb_valid); end
    endtask

    task automatic test_single();
        do_reset();
        set_src(2'd0, 64'h1234, 8'd5, 8'd3, 1'b0, 8'h00);
        step();
        idle();
        total++; if (wb_valid !== 2'b01) begin bad++; $display("FAIL single_valid got=%b exp=01", wb_valid); end
        total++; if (wb_result[0] !== 64'h1234) begin bad++; $display("FAIL single_result got=%h exp=1234", wb_result[0]); end
        total++; if (wb_dst_tag[0] !== 8'd5 || wb_rob_idx[0] !== 8'd3) begin bad++; $display("FAIL single_tag_rob got=%0d/%0d exp=5/3", wb_dst_tag[0], wb_rob_idx[0]); end
        total++; if (wb_result[1] !== '0) begin bad++; $display("FAIL single_port1_data got=%h exp=0", wb_result[1]); end
        step();
        total++; if (wb_valid !== 2'b00) begin bad++; $display("FAIL single_no_push got=%b exp=00", wb_valid); end
    endtask

    task automatic test_all4();
        do_reset();
        for (int s = 0; s < NS; s++) set_src(2'(s), XLEN'(32'h100 + s), 8'(10 + s), 8'(20 + s), 1'b0, 8'h00);
        step();
        idle();
        total++; if (wb_valid !== 2'b11 || wb_result[0] !== 64'h100 || wb_result[1] !== 64'h101) begin
            bad++; $display("FAIL all4_first got=%b %h %h exp=11 100 101", wb_valid, wb_result[0], wb_result[1]); end
        step();
        total++; if (wb_valid !== 2'b11 || wb_result[0] !== 64'h102 || wb_result[1] !== 64'h103) begin
            bad++; $display("FAIL all4_second got=%b %h %h exp=11 102 103", wb_valid, wb_result[0], wb_result[1]); end
        total++; if (wb_dst_tag[1] !== 8'd13 || wb_rob_idx[1] !== 8'd23) begin bad++; $display("FAIL all4_tags got=%0d/%0d exp=13/23", wb_dst_tag[1], wb_rob_idx[1]); end
        step();
        total++; if (wb_valid !== 2'b00) begin bad++; $display("FAIL all4_drained got=%b exp=00", wb_valid); end
        for (int s = 0; s < NS; s++) set_src(2'(s), XLEN'(32'h200 + s), 8'(10 + s), 8'(20 + s), 1'b0, 8'h00);
        step();
        idle();
        total++; if (wb_result[0] !== 64'h200 || wb_result[1] !== 64'h201) begin
            bad++; $display("FAIL all4_rr_back_to_0 got=%h %h exp=200 201", wb_result[0], wb_result[1]); end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        int seq [NS];
        int exp_seq [NS];
        int grants [NS];
        int sid;
        int ev;
        logic saw_stall;
        do_reset();
        saw_stall = 1'b0;
        for (int s = 0; s < NS; s++) begin seq[s] = 0; exp_seq[s] = 0; grants[s] = 0; end
        for (int c = 0; c < 24; c++) begin
            idle();
            for (int s = 0; s < NS; s++) begin
                if (c < 16 && !src_stall[s]) begin
                    set_src(2'(s), XLEN'(s * 4096 + seq[s]), 8'(s), 8'(c), 1'b0, 8'h00);
                    seq[s]++;
                end
            end
            step();
            if (|src_stall) saw_stall = 1'b1;
            if (c == 2) begin
                total++; if (src_stall !== 4'b1100) begin bad++; $display("FAIL b2b_stall_c2 got=%b exp=1100", src_stall); end
            end
            if (c == 3) begin
                total++; if (src_stall !== 4'b0011) begin bad++; $display("FAIL b2b_stall_c3 got=%b exp=0011", src_stall); end
            end
            for (int p = 0; p < NW; p++) begin
                if (wb_valid[p]) begin
                    sid = int'(wb_dst_tag[p][1:0]);
                    ev  = sid * 4096 + exp_seq[sid];
                    total++; if (wb_result[p] !== XLEN'(ev)) begin bad++; $display("FAIL b2b_order src=%0d got=%h exp=%h", sid, wb_result[p], ev); end
                    exp_seq[sid]++;
                    if (c < 16) grants[sid]++;
                end
            end
        end
        idle();
        for (int s = 0; s < NS; s++) begin
            total++; if (grants[s] != 8) begin bad++; $display("FAIL b2b_fairness src=%0d got=%0d exp=8", s, grants[s]); end
            total++; if (exp_seq[s] != seq[s]) begin bad++; $display("FAIL b2b_all_delivered src=%0d got=%0d exp=%0d", s, exp_seq[s], seq[s]); end
        end
        total++; if (saw_stall !== 1'b1) begin bad++; $display("FAIL b2b_stall_seen got=%b exp=1", saw_stall); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL b2b_no_overflow got=%b exp=0", overflow_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            for (int s = 0; s < NS; s++) set_src(2'(s), XLEN'(c), 8'(s), 8'(c), 1'b0, 8'h00);
            step();
            if (c == 7) begin
                total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_full_with_pop got=%b exp=0", overflow_err); end
            end
        end
        idle();
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow_err); end
        for (int c = 0; c < 10; c++) step();
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_survives_flush got=%b exp=1", overflow_err); end
    endtask

    task automatic test_flush();
        logic stale;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int s = 0; s < NS; s++) set_src(2'(s), XLEN'(32'hF00 + c), 8'(s), 8'(c), 1'b0, 8'h00);
            step();
        end
        total++; if (src_stall !== 4'hF) begin bad++; $display("FAIL flush_pre_stall got=%h exp=f", src_stall); end
        for (int s = 0; s < NS; s++) set_src(2'(s), XLEN'(32'hDEAD), 8'(s), 8'd0, 1'b0, 8'h00);
        flush = 1'b1;
        step();
        idle();
        total++; if (wb_valid !== 2'b00) begin bad++; $display("FAIL flush_wb_valid got=%b exp=00", wb_valid); end
        total++; if (src_stall !== 4'h0) begin bad++; $display("FAIL flush_src_stall got=%h exp=0", src_stall); end
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (wb_valid !== 2'b00) stale = 1'b1;
        end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL flush_no_stale got=%b exp=0", stale); end
        set_src(2'd3, 64'hBEEF, 8'd7, 8'd9, 1'b0, 8'h00);
        step();
        idle();
        total++; if (wb_valid !== 2'b01 || wb_result[0] !== 64'hBEEF) begin
            bad++; $display("FAIL flush_fresh got=%b %h exp=01 beef", wb_valid, wb_result[0]); end
    endtask

    task automatic test_exception();
        do_reset();
        set_src(2'd0, 64'h10, 8'd1, 8'd1, 1'b0, 8'h00);
        set_src(2'd1, 64'h11, 8'd2, 8'd2, 1'b0, 8'h00);
        set_src(2'd2, 64'hA, 8'd3, 8'd3, 1'b0, 8'h00);
        step();
        idle();
        set_src(2'd2, 64'hB, 8'd4, 8'd4, 1'b1, 8'h0D);
        total++; if (wb_valid !== 2'b11 || wb_exception !== 2'b00) begin bad++; $display("FAIL exc_first got=%b/%b exp=11/00", wb_valid, wb_exception); end
        step();
        idle();
        total++; if (wb_valid !== 2'b01 || wb_result[0] !== 64'hA || wb_exception[0] !== 1'b0) begin
            bad++; $display("FAIL exc_order_head got=%b %h %b exp=01 a 0", wb_valid, wb_result[0], wb_exception[0]); end
        step();
        total++; if (wb_valid !== 2'b01 || wb_result[0] !== 64'hB) begin bad++; $display("FAIL exc_entry got=%b %h exp=01 b", wb_valid, wb_result[0]); end
        total++; if (wb_exception[0] !== 1'b1 || wb_exception_code[0] !== 8'h0D) begin
            bad++; $display("FAIL exc_fields got=%b %h exp=1 0d", wb_exception[0], wb_exception_code[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_exception();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
